// File: rtl/fsqrt_arbiter.sv
// Round-robin arbiter sharing one fixed-latency fsqrt core; results are tagged and returned via a credit-protected FIFO.
// Optional statistics counters are enabled with `define FSQRT_ARB_STATS_EN.
module fsqrt_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 12,
    parameter int LAT   = 1,
    parameter int DEPTH = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      core_x,
    input  logic [WIDTH-1:0]      core_r,
    output logic                  resp_valid,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_data,
    input  logic                  resp_ready,
    output logic                  busy
`ifdef FSQRT_ARB_STATS_EN
    ,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           ops_cnt
`endif
);

    localparam int          CW = $clog2(DEPTH + LAT + 2);
    localparam int          PW = $clog2(DEPTH);
    localparam int unsigned NR = NREQ;
    localparam int unsigned NL = LAT;

    logic [IDW-1:0]       ptr;
    logic                 issue_v;
    logic [IDW-1:0]       issue_id;
    logic [LAT-1:0]       tag_v;
    logic [IDW-1:0]       tag_id [LAT];
    logic [IDW+WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        fifo_count, inflight;
    logic                 credit_ok, found, accept, push, pop;
    logic [IDW-1:0]       win_id;
    logic [WIDTH-1:0]     win_data;
    int unsigned          cand;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = CW'(issue_v);
        for (int unsigned i = 0; i < NL; i++) begin
            inflight = inflight + CW'(tag_v[i]);
        end
    end

    // Registered occupancy only: a pop in this cycle frees its slot next cycle.
    assign credit_ok = (fifo_count + inflight) < CW'(DEPTH);

    always_comb begin
        found  = 1'b0;
        win_id = '0;
        cand   = 0;
        for (int unsigned k = 1; k <= NR; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NR) begin
                cand = cand - NR;
            end
            if (!found && req_valid[IDW'(cand)]) begin
                found  = 1'b1;
                win_id = IDW'(cand);
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (IDW'(i) == win_id) begin
                win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && found && credit_ok) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign accept     = |req_ready;
    assign push       = tag_v[LAT-1];
    assign resp_valid = (fifo_count != '0);
    assign pop        = resp_valid & resp_ready;
    assign {resp_id, resp_data} = mem[rd_ptr];
    assign busy       = issue_v | (|tag_v) | resp_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr        <= IDW'(NREQ - 1);
            issue_v    <= 1'b0;
            issue_id   <= '0;
            core_x     <= '0;
            tag_v      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            issue_v <= accept;
            if (accept) begin
                ptr      <= win_id;
                issue_id <= win_id;
                core_x   <= win_data;
            end
            tag_v[0] <= issue_v;
            for (int unsigned i = 1; i < NL; i++) begin
                tag_v[i] <= tag_v[i-1];
            end
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!push && pop) fifo_count <= fifo_count - 1'b1;
        end
    end

    // Tag ids and FIFO payload need no reset; the valid bits and count qualify them.
    always_ff @(posedge clk) begin
        tag_id[0] <= issue_id;
        for (int unsigned i = 1; i < NL; i++) begin
            tag_id[i] <= tag_id[i-1];
        end
        if (rst_n && push) begin
            mem[wr_ptr] <= {tag_id[LAT-1], core_r};
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) push |-> (fifo_count < CW'(DEPTH)));

`ifdef FSQRT_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            ops_cnt   <= '0;
        end else begin
            if ((|req_valid) && !accept && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (accept) begin
                ops_cnt <= ops_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Directed bench for fsqrt_arbiter with a stand-in 1-cycle core (result = operand ^ 12'h5A5).
module tb_fsqrt_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 12;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;
    localparam int IDW   = 2;
    localparam logic [11:0] MASK = 12'h5A5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      core_x;
    logic [WIDTH-1:0]      core_r;
    logic                  resp_valid;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_data;
    logic                  resp_ready;
    logic                  busy;
`ifdef FSQRT_ARB_STATS_EN
    logic [15:0]           stall_cnt;
    logic [15:0]           ops_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [11:0] dv [4];

    fsqrt_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH),
        .LAT  (LAT),
        .DEPTH(DEPTH),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .core_x    (core_x),
        .core_r    (core_r),
        .resp_valid(resp_valid),
        .resp_id   (resp_id),
        .resp_data (resp_data),
        .resp_ready(resp_ready),
        .busy      (busy)
`ifdef FSQRT_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .ops_cnt   (ops_cnt)
`endif
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) core_r <= core_x ^ MASK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rsp(input int i);
        return 32'(dv[i] ^ MASK);
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        dv[0] = 12'h0F1; dv[1] = 12'h7FF; dv[2] = 12'h1A0; dv[3] = 12'h800;
        req_data   = {dv[3], dv[2], dv[1], dv[0]};
        rst_n      = 1'b0;
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        step();
        step();
        check("rst req_ready", 32'(req_ready), 0);
        check("rst resp_valid", 32'(resp_valid), 0);
        check("rst busy", 32'(busy), 0);
        check("rst core_x", 32'(core_x), 0);
        req_valid = '0;
        rst_n     = 1'b1;

        // single op from requester 2
        req_valid = 4'b0100;
        #1;
        check("single grant", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        check("single core_x", 32'(core_x), 32'h1A0);
        check("single c1 valid", 32'(resp_valid), 0);
        step();
        check("single c2 valid", 32'(resp_valid), 0);
        step();
        check("single c3 valid", 32'(resp_valid), 1);
        check("single c3 id", 32'(resp_id), 2);
        check("single c3 data", 32'(resp_data), 32'h405);
        step();
        check("single c4 busy", 32'(busy), 0);
        check("single c4 valid", 32'(resp_valid), 0);

        // round robin from reset
        do_reset();
        for (int k = 0; k < 11; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            if (k < 8) check("rr grant", 32'(req_ready), 32'(1) << (k % 4));
            if (k >= 3) begin
                check("rr valid", 32'(resp_valid), 1);
                check("rr id", 32'(resp_id), 32'((k - 3) % 4));
                check("rr data", 32'(resp_data), rsp((k - 3) % 4));
            end
            step();
        end
        check("rr idle busy", 32'(busy), 0);

        // back-pressure: only DEPTH accepts fit
        do_reset();
        resp_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            req_valid = 4'b0011;
            #1;
            check("bp grant", 32'(req_ready), (k < 4) ? ((k % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
            step();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("bp drain valid", 32'(resp_valid), 1);
            check("bp drain id", 32'(resp_id), 32'(j % 2));
            check("bp drain data", 32'(resp_data), rsp(j % 2));
            step();
        end
        check("bp empty", 32'(resp_valid), 0);

        // simultaneous push and pop with two entries queued
        do_reset();
        resp_ready = 1'b0;
        req_valid = 4'b0001; step();
        req_valid = 4'b0010; step();
        req_valid = 4'b0100; step();
        req_valid = 4'b0000; step();
        resp_ready = 1'b1;
        #1;
        check("pp c4 count", 32'(dut.fifo_count), 2);
        check("pp c4 id", 32'(resp_id), 0);
        step();
        check("pp c5 count", 32'(dut.fifo_count), 2);
        check("pp c5 id", 32'(resp_id), 1);
        check("pp c5 data", 32'(resp_data), rsp(1));
        step();
        check("pp c6 id", 32'(resp_id), 2);
        check("pp c6 data", 32'(resp_data), rsp(2));
        step();
        check("pp c7 valid", 32'(resp_valid), 0);

        // reset while three ops are in flight
        resp_ready = 1'b0;
        req_valid = 4'b0010; step();
        req_valid = 4'b0100; step();
        req_valid = 4'b1000; step();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        #1;
        check("mid rst ready", 32'(req_ready), 0);
        step();
        rst_n      = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        check("mid post busy", 32'(busy), 0);
        for (int k = 0; k < 4; k++) begin
            check("mid no stale", 32'(resp_valid), 0);
            step();
        end
        req_valid = 4'hF;
        #1;
        check("mid first grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;

`ifdef FSQRT_ARB_STATS_EN
        do_reset();
        resp_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            req_valid = 4'b0001;
            step();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'b0001;
            step();
        end
        req_valid = '0;
        step();
        check("stats stall", 32'(stall_cnt), 5);
        check("stats ops", 32'(ops_cnt), 7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
